// File: rtl/spikey_spi_target_if.sv
// Bundle of SPI pad signals and the TX/RX word interface of the spikey SPI target.
interface spikey_spi_target_if #(
    parameter int unsigned WIDTH = 8
);
    logic             SCK;
    logic             CS_N;
    logic             MOSI;
    logic             MISO;
    logic             MISO_OE;
    logic [WIDTH-1:0] TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic             TX_UNDERRUN;
    logic             BUSY;

    modport slave (
        input  SCK, CS_N, MOSI, TX_DATA, TX_VALID,
        output MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN, BUSY
    );

    modport master (
        output SCK, CS_N, MOSI, TX_DATA, TX_VALID,
        input  MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN, BUSY
    );
endinterface

// File: rtl/spikey_spi_target.sv
// SPI mode-0 target: pads oversampled in FCLK, pulse RX word output, one-entry TX holding buffer.
module spikey_spi_target #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                 FCLK,
    input logic                 RST_N,
    spikey_spi_target_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_dly_q, sck_dly_d;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic                   miso_q, miso_d;
    logic                   pending_q, pending_d;
    logic                   underrun_q, underrun_d;
    logic [WIDTH-1:0]       buf_q, buf_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   busy_q, busy_d;

    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall;
    logic                   load;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;

    // Pad synchronizers plus one SCK delay flop for edge detection
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.CS_N};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
        sck_dly_d   = sck_s;
    end

    // Frame control, shifting, word loads and holding buffer
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_shift_d = tx_shift_q;
        miso_d     = miso_q;
        pending_d  = pending_q;
        underrun_d = 1'b0;
        buf_d      = buf_q;
        tx_ready_d = tx_ready_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    pending_d = 1'b0;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    // Deselect wins over any coincident SCK edge; partial word is dropped
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    pending_d  = 1'b0;
                    rx_shift_d = '0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        pending_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (pending_q) begin
                        load      = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[WIDTH-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (!tx_ready_q) begin
                tx_shift_d = buf_q;
                miso_d     = buf_q[WIDTH-1];
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d = '0;
                miso_d     = 1'b0;
                underrun_d = 1'b1;
            end
        end

        // A write is only accepted into an empty buffer, so it never collides with a consuming load
        if (bus.TX_VALID && tx_ready_q) begin
            buf_d      = bus.TX_DATA;
            tx_ready_d = 1'b0;
        end

        busy_d = (state_d == ACTIVE);
    end

    always_ff @(posedge FCLK or negedge RST_N) begin
        if (!RST_N) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            pending_q   <= 1'b0;
            underrun_q  <= 1'b0;
            buf_q       <= '0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_dly_q   <= sck_dly_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            pending_q   <= pending_d;
            underrun_q  <= underrun_d;
            buf_q       <= buf_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.MISO        = miso_q;
    assign bus.MISO_OE     = busy_q;
    assign bus.BUSY        = busy_q;
    assign bus.TX_READY    = tx_ready_q;
    assign bus.RX_DATA     = rx_data_q;
    assign bus.RX_VALID    = rx_valid_q;
    assign bus.TX_UNDERRUN = underrun_q;

endmodule

// File: tb/tb_spikey_spi_target.sv
// Directed bench for spikey_spi_target: table of single-word frames plus multi-cycle corner sequences.
module tb_spikey_spi_target;
    localparam int unsigned WIDTH = 8;

    logic FCLK;
    logic RST_N;

    spikey_spi_target_if #(.WIDTH(WIDTH)) bus ();

    spikey_spi_target #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .FCLK  (FCLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    int checks = 0;
    int errors = 0;

    int         rxv_cnt = 0;
    int         unr_cnt = 0;
    logic [7:0] rx_hist[$];

    // Pulse monitor: a pulse longer than one cycle inflates the counts
    always @(negedge FCLK) begin
        if (bus.RX_VALID === 1'b1) begin
            rxv_cnt = rxv_cnt + 1;
            rx_hist.push_back(bus.RX_DATA);
        end
        if (bus.TX_UNDERRUN === 1'b1) unr_cnt = unr_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge FCLK);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        bus.TX_DATA  = d;
        bus.TX_VALID = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge FCLK);
            if (bus.TX_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge FCLK);
        #1;
        bus.TX_VALID = 1'b0;
        check("tx_write_accepted", 32'(ok), 32'd1);
    endtask

    // Mode-0 frame at SCK = FCLK/8; the final SCK fall coincides with CS_N rise.
    // With coincide set, CS_N rises together with the last SCK rise instead.
    task automatic frame(input logic [15:0] mosi, input int nbits, input bit coincide,
                         output logic [15:0] miso);
        miso     = '0;
        bus.CS_N = 1'b0;
        bus.MOSI = mosi[nbits-1];
        cyc(4);
        for (int i = 0; i < nbits; i++) begin
            miso    = {miso[14:0], bus.MISO};
            bus.SCK = 1'b1;
            if (coincide && i == nbits - 1) bus.CS_N = 1'b1;
            cyc(4);
            bus.SCK = 1'b0;
            if (i == nbits - 1) begin
                bus.CS_N = 1'b1;
            end else begin
                bus.MOSI = mosi[nbits-2-i];
                cyc(4);
            end
        end
        cyc(6);
    endtask

    typedef struct {
        bit         preload;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_unr;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] m;
    int          rx0, un0, h0;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'h00, 8'h5A, 1};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0};
        vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80, 0};

        RST_N        = 1'b0;
        bus.SCK      = 1'b0;
        bus.CS_N     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.TX_DATA  = '0;
        bus.TX_VALID = 1'b0;
        cyc(3);
        check("rst_miso", 32'(bus.MISO), 32'd0);
        check("rst_miso_oe", 32'(bus.MISO_OE), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_rx_data", 32'(bus.RX_DATA), 32'd0);
        check("rst_rx_valid", 32'(bus.RX_VALID), 32'd0);
        check("rst_underrun", 32'(bus.TX_UNDERRUN), 32'd0);
        check("rst_tx_ready", 32'(bus.TX_READY), 32'd1);
        RST_N = 1'b1;
        cyc(3);

        for (int v = 0; v < 4; v++) begin
            rx0 = rxv_cnt;
            un0 = unr_cnt;
            if (vecs[v].preload) begin
                tx_write(vecs[v].tx);
                check("vec_tx_ready_low", 32'(bus.TX_READY), 32'd0);
            end
            frame({8'h00, vecs[v].mosi}, 8, 1'b0, m);
            check("vec_miso_bits", 32'(m[7:0]), 32'(vecs[v].exp_miso));
            check("vec_rx_data", 32'(bus.RX_DATA), 32'(vecs[v].exp_rx));
            check("vec_rx_valid_pulses", 32'(rxv_cnt - rx0), 32'd1);
            check("vec_underrun_pulses", 32'(unr_cnt - un0), 32'(vecs[v].exp_unr));
            check("vec_tx_ready_after", 32'(bus.TX_READY), 32'd1);
            check("vec_busy_after", 32'(bus.BUSY), 32'd0);
            check("vec_miso_oe_after", 32'(bus.MISO_OE), 32'd0);
        end

        // Back-to-back: second word written while the first shifts out
        rx0 = rxv_cnt;
        un0 = unr_cnt;
        h0  = rx_hist.size();
        tx_write(8'h11);
        fork
            frame(16'hF00F, 16, 1'b0, m);
            begin
                cyc(12);
                tx_write(8'h22);
            end
        join
        check("b2b_miso", 32'(m), 32'h1122);
        check("b2b_rx_pulses", 32'(rxv_cnt - rx0), 32'd2);
        check("b2b_rx_first", 32'(rx_hist[h0]), 32'hF0);
        check("b2b_rx_second", 32'(rx_hist[h0+1]), 32'h0F);
        check("b2b_underrun", 32'(unr_cnt - un0), 32'd0);

        // Abort after 5 rises; the loaded word is dropped
        rx0 = rxv_cnt;
        tx_write(8'h77);
        frame(16'h0016, 5, 1'b0, m);
        check("abort_no_rx_valid", 32'(rxv_cnt - rx0), 32'd0);
        check("abort_rx_data_held", 32'(bus.RX_DATA), 32'h0F);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        un0 = unr_cnt;
        tx_write(8'h3E);
        frame(16'h0081, 8, 1'b0, m);
        check("abort_next_rx", 32'(bus.RX_DATA), 32'h81);
        check("abort_next_rx_pulses", 32'(rxv_cnt - rx0), 32'd1);
        check("abort_next_miso", 32'(m[7:0]), 32'h3E);
        check("abort_next_underrun", 32'(unr_cnt - un0), 32'd0);

        // CS_N rise together with the 8th SCK rise
        rx0 = rxv_cnt;
        un0 = unr_cnt;
        frame(16'h005A, 8, 1'b1, m);
        check("coin_no_rx_valid", 32'(rxv_cnt - rx0), 32'd0);
        check("coin_busy", 32'(bus.BUSY), 32'd0);
        check("coin_underrun_at_cs", 32'(unr_cnt - un0), 32'd1);
        frame(16'h0024, 8, 1'b0, m);
        check("coin_next_rx", 32'(bus.RX_DATA), 32'h24);
        check("coin_next_rx_pulses", 32'(rxv_cnt - rx0), 32'd1);

        // Reset mid-frame after 3 bits, with a full buffer and nonzero RX_DATA
        bus.CS_N = 1'b0;
        bus.MOSI = 1'b1;
        cyc(4);
        repeat (3) begin
            bus.SCK = 1'b1;
            cyc(4);
            bus.SCK = 1'b0;
            cyc(4);
        end
        tx_write(8'h5A);
        check("mid_busy_before_rst", 32'(bus.BUSY), 32'd1);
        check("mid_tx_ready_before_rst", 32'(bus.TX_READY), 32'd0);
        RST_N = 1'b0;
        #2;
        check("arst_miso", 32'(bus.MISO), 32'd0);
        check("arst_miso_oe", 32'(bus.MISO_OE), 32'd0);
        check("arst_busy", 32'(bus.BUSY), 32'd0);
        check("arst_rx_data", 32'(bus.RX_DATA), 32'd0);
        check("arst_rx_valid", 32'(bus.RX_VALID), 32'd0);
        check("arst_underrun", 32'(bus.TX_UNDERRUN), 32'd0);
        check("arst_tx_ready", 32'(bus.TX_READY), 32'd1);
        bus.CS_N = 1'b1;
        bus.SCK  = 1'b0;
        cyc(3);
        RST_N = 1'b1;
        cyc(3);
        rx0 = rxv_cnt;
        tx_write(8'hC3);
        frame(16'h0096, 8, 1'b0, m);
        check("post_rst_miso", 32'(m[7:0]), 32'hC3);
        check("post_rst_rx", 32'(bus.RX_DATA), 32'h96);
        check("post_rst_rx_pulses", 32'(rxv_cnt - rx0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
